// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding HI/LO; one result bit per clock.
// Define MULDIV_DIV_EN to build the divider (DIV/DIVU and divide-by-zero reporting).
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;

    logic               sa, sb, accept;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

`ifdef MULDIV_DIV_EN
    logic               is_div_q, is_div_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic               divzero_q, divzero_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   quo, rem;

    assign accept  = start && (state_q == StIdle);
    assign divzero = divzero_q;
`else
    assign accept  = start && (state_q == StIdle) && !op[1];
    assign divzero = 1'b0;
`endif

    // op[0] set means unsigned, so no sign flags
    assign sa    = ~op[0] & a[WIDTH-1];
    assign sb    = ~op[0] & b[WIDTH-1];
    assign mag_a = sa ? -a : a;
    assign mag_b = sb ? -b : b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        sum     = '0;
        prod    = '0;
`ifdef MULDIV_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        divzero_d = 1'b0;
        rem_d     = rem_q;
        shifted   = '0;
        quo       = '0;
        rem       = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d   = '0;
                    neg_d   = sa ^ sb;
                    state_d = StRun;
`ifdef MULDIV_DIV_EN
                    is_div_d  = op[1];
                    neg_rem_d = sa;
                    dz_d      = 1'b0;
                    rem_d     = '0;
                    if (op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                        opnd_d = mag_b;
                        // Divide by zero skips RUN; acc carries the final HI/LO pair
                        if (b == '0) begin
                            acc_d   = {a, {WIDTH{1'b1}}};
                            dz_d    = 1'b1;
                            state_d = StFix;
                        end
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                        opnd_d = mag_a;
                    end
`else
                    acc_d  = {{WIDTH{1'b0}}, mag_b};
                    opnd_d = mag_a;
`endif
                end else begin
                    if (hi_we) hi_d = wd;
                    if (lo_we) lo_d = wd;
                end
            end
            StRun: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) state_d = StFix;
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    shifted = {rem_q, acc_q[WIDTH-1]};
                    if (shifted >= {1'b0, opnd_q}) begin
                        rem_d              = shifted[WIDTH-1:0] - opnd_q;
                        acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d              = shifted[WIDTH-1:0];
                        acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b0};
                    end
                end else
`endif
                begin
                    // Upper half accumulates; multiplier bits shift out of the lower half
                    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                            (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
                divzero_d = dz_q;
                quo       = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                rem       = neg_rem_q ? -rem_q : rem_q;
                if (dz_q) begin
                    hi_d = acc_q[2*WIDTH-1:WIDTH];
                    lo_d = acc_q[WIDTH-1:0];
                end else if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else
`endif
                begin
                    prod = neg_q ? -acc_q : acc_q;
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            divzero_q <= 1'b0;
            rem_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MULDIV_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            divzero_q <= divzero_d;
            rem_q     <= rem_d;
`endif
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/divzero queued at launch, checked on done.
// Divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;
    logic        clk, reset, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wd;
    logic        busy, done, divzero;
    logic [31:0] hi, lo;

`ifdef MULDIV_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] model_hi, model_lo;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wd      (wd),
        .busy    (busy),
        .done    (done),
        .divzero (divzero),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Architectural MIPS results from plain integer arithmetic
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        r;
        longint      sp;
        logic [63:0] up;
        int          sx, sy;
        r = '0;
        case (o)
            2'd0: begin
                sp   = longint'($signed(x)) * longint'($signed(y));
                r.hi = sp[63:32];
                r.lo = sp[31:0];
            end
            2'd1: begin
                up   = {32'd0, x} * {32'd0, y};
                r.hi = up[63:32];
                r.lo = up[31:0];
            end
            default: begin
                if (y == 32'd0) begin
                    r.hi = x;
                    r.lo = 32'hFFFF_FFFF;
                    r.dz = 1'b1;
                end else if (o == 2'd3) begin
                    r.lo = x / y;
                    r.hi = x % y;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    r.lo = 32'h8000_0000;
                    r.hi = 32'd0;
                end else begin
                    sx   = x;
                    sy   = y;
                    r.lo = sx / sy;
                    r.hi = sx % sy;
                end
            end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no completion");
            end else begin
                e = exp_q.pop_front();
                check("result_hi", 64'(hi), 64'(e.hi));
                check("result_lo", 64'(lo), 64'(e.lo));
                check("result_divzero", 64'(divzero), 64'(e.dz));
            end
        end
    end

    // Called just after a negedge; returns at the negedge where done is expected
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int   nb;
        int   lat;
        bit   acc;
        acc   = !o[1] || DivEn;
        e     = model(o, x, y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (acc) exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        if (acc) begin
            lat = (o[1] && y == 32'd0) ? 1 : 33;
            nb  = 0;
            do begin
                @(negedge clk);
                if (busy) nb++;
            end while (busy && nb <= 40);
            check("busy_cycles", 64'(nb), 64'(lat));
            check("done_at_idle", 64'(done), 64'd1);
            model_hi = e.hi;
            model_lo = e.lo;
        end else begin
            @(negedge clk);
            check("ignored_busy", 64'(busy), 64'd0);
            check("ignored_hi", 64'(hi), 64'(model_hi));
            check("ignored_lo", 64'(lo), 64'(model_lo));
        end
    endtask

    initial begin
        int nb;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wd    = '0;
        model_hi = '0;
        model_lo = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_divzero", 64'(divzero), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);

        do_op(2'd1, 32'hFFFF_FFFF, 32'd2);
        check("multu_hi", 64'(hi), 64'h1);
        check("multu_lo", 64'(lo), 64'hFFFF_FFFE);
        do_op(2'd0, 32'hFFFF_FFFD, 32'd7);
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFEB);
`ifdef MULDIV_DIV_EN
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi), 64'hFFFF_FFFF);
        do_op(2'd3, 32'd100, 32'd7);
        check("divu_lo", 64'(lo), 64'd14);
        check("divu_hi", 64'(hi), 64'd2);
        do_op(2'd3, 32'h1234, 32'd0);
        check("dz_flag", 64'(divzero), 64'd1);
        check("dz_hi", 64'(hi), 64'h1234);
        check("dz_lo", 64'(lo), 64'hFFFF_FFFF);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf_lo", 64'(lo), 64'h8000_0000);
        check("ovf_hi", 64'(hi), 64'd0);
`else
        do_op(2'd3, 32'h1234, 32'd0);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2);
`endif

        // MTHI / MTLO in IDLE
        hi_we = 1'b1;
        wd    = 32'hA5A5_A5A5;
        @(posedge clk);
        #1 hi_we = 1'b0;
        @(negedge clk);
        check("mthi", 64'(hi), 64'hA5A5_A5A5);
        model_hi = 32'hA5A5_A5A5;
        lo_we = 1'b1;
        wd    = 32'h0F0F_1234;
        @(posedge clk);
        #1 lo_we = 1'b0;
        @(negedge clk);
        check("mtlo", 64'(lo), 64'h0F0F_1234);
        model_lo = 32'h0F0F_1234;

        // Restart and MTLO while running are both ignored
        start = 1'b1;
        op    = 2'd1;
        a     = 32'd5;
        b     = 32'd6;
        exp_q.push_back(model(2'd1, 32'd5, 32'd6));
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = 2'd1;
        a     = 32'd7;
        b     = 32'd9;
        lo_we = 1'b1;
        wd    = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        lo_we = 1'b0;
        @(negedge clk);
        check("mtlo_in_run", 64'(lo), 64'(model_lo));
        nb = 0;
        while (busy && nb < 40) begin
            @(negedge clk);
            nb++;
        end
        check("restart_idle", 64'(busy), 64'd0);
        check("restart_lo", 64'(lo), 64'd30);
        model_hi = 32'd0;
        model_lo = 32'd30;

        // Reset at edge 10 discards the operation
        @(negedge clk);
        start = 1'b1;
        op    = 2'd1;
        a     = 32'd5;
        b     = 32'd6;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_hi", 64'(hi), 64'd0);
        check("midreset_lo", 64'(lo), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        model_hi = '0;
        model_lo = '0;
        repeat (40) @(negedge clk);

        // Random back-to-back operations
        for (int i = 0; i < 48; i++) begin
            logic [1:0]  o;
            logic [31:0] x, y;
            int          r;
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
            r = $urandom_range(0, 7);
            y = $urandom;
            if (r == 0) y = 32'd0;
            else if (r == 1) y = 32'hFFFF_FFFF;
            else if (r == 2) y = $urandom_range(1, 15);
            do_op(o, x, y);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
